bootrom_param: RTL and testbench

Parametrised boot ROM with a writable patch region, the next generation of the SoC boot memory. It holds a fixed reset-vector image in the low words and a RAM patch area above it, which the SPI loader fills before the CPU jumps there. Reads are registered with a valid strobe. The patch area can be write-locked until reset. A running checksum of the patch area lets firmware verify a download without re-reading it.

---
 rtl/bootrom_param.sv | 63 ++++++
 tb/tb_bootrom_param.sv | 117 +++++++++++
 2 files changed

// File: rtl/bootrom_param.sv
// bootrom_param: fixed boot ROM image with a lockable patch RAM, registered reads and a running patch checksum
module bootrom_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 12,
  parameter int ROM_WORDS = 7,
  parameter logic [DATA_W*ROM_WORDS-1:0] ROM_INIT =
    {16'h4000, 16'h3008, 16'hF400, 16'h1007, 16'hF800, 16'h4000, 16'hF200}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              lock,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              err,
  output logic              locked,
  output logic [DATA_W-1:0] csum
);
  localparam int PW = DEPTH - ROM_WORDS;
  logic [DATA_W-1:0] patch [PW];
  logic [31:0] a_ext;
  logic in_rom, in_patch, mapped, wr_ok;
  logic [DATA_W-1:0] rom_word, patch_word, rd_word;
  assign a_ext = 32'(addr);
  assign in_rom = a_ext < ROM_WORDS;
  assign mapped = a_ext < DEPTH;
  assign in_patch = mapped && !in_rom;
  assign wr_ok = cs && we && in_patch && !locked && !lock;
  assign rd_word = in_rom ? rom_word : patch_word;
  always_comb begin
    rom_word = '0;
    patch_word = '0;
    for (int k = 0; k < ROM_WORDS; k++)
      if (a_ext == k) rom_word = ROM_INIT[k*DATA_W +: DATA_W];
    for (int k = 0; k < PW; k++)
      if (a_ext == ROM_WORDS + k) patch_word = patch[k];
  end
  // the checksum reuses the read mux output as the word being replaced
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      rvalid <= 1'b0;
      err <= 1'b0;
      locked <= 1'b0;
      csum <= '0;
      for (int k = 0; k < PW; k++) patch[k] <= '0;
    end else begin
      rvalid <= cs && !we;
      err <= cs && (we ? !wr_ok : !mapped);
      if (cs && !we) dout <= mapped ? rd_word : '0;
      if (lock) locked <= 1'b1;
      if (wr_ok) begin
        csum <= csum - patch_word + din;
        for (int k = 0; k < PW; k++)
          if (a_ext == ROM_WORDS + k) patch[k] <= din;
      end
    end
  end
endmodule

// File: tb/tb_bootrom_param.sv
// tb_bootrom_param: table-driven directed checks of the boot ROM, patch RAM, lock and checksum
module tb_bootrom_param;
  logic clk = 1'b0;
  logic rst, cs, we, lock;
  logic [3:0] addr;
  logic [15:0] din, dout, csum;
  logic rvalid, err, locked;
  int n_chk = 0, n_fail = 0;

  bootrom_param dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .lock(lock),
    .dout(dout), .rvalid(rvalid), .err(err), .locked(locked), .csum(csum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, c, w;
    logic [3:0] a;
    logic [15:0] d;
    logic l;
    logic [15:0] e_dout;
    logic e_rv, e_err, e_lck;
    logic [15:0] e_csum;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic r, logic c, logic w, logic [3:0] a, logic [15:0] d, logic l,
                              logic [15:0] ed, logic erv, logic ee, logic el, logic [15:0] ec);
    vec_t v;
    v.r = r; v.c = c; v.w = w; v.a = a; v.d = d; v.l = l;
    v.e_dout = ed; v.e_rv = erv; v.e_err = ee; v.e_lck = el; v.e_csum = ec;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(logic r, logic c, logic w, logic [3:0] a, logic [15:0] d, logic l);
    rst = r; cs = c; we = w; addr = a; din = d; lock = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(int idx, vec_t v);
    check("dout", idx, dout, v.e_dout);
    check("rvalid", idx, 16'(rvalid), 16'(v.e_rv));
    check("err", idx, 16'(err), 16'(v.e_err));
    check("locked", idx, 16'(locked), 16'(v.e_lck));
    check("csum", idx, csum, v.e_csum);
  endtask

  logic [15:0] rom_img [7] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3008, 16'h4000};

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0; lock = 1'b0;
    // r c w addr din lock | dout rv err lck csum
    tv.push_back(mk(1, 0, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(0, 1, 0, 4'(i), 16'h0, 0, rom_img[i], 1, 0, 0, 16'h0000));
    tv.push_back(mk(0, 1, 1, 4'h7, 16'h1234, 0, 16'h4000, 0, 0, 0, 16'h1234));
    tv.push_back(mk(0, 1, 1, 4'h8, 16'hABCD, 0, 16'h4000, 0, 0, 0, 16'hBE01));
    tv.push_back(mk(0, 1, 0, 4'h7, 16'h0000, 0, 16'h1234, 1, 0, 0, 16'hBE01));
    tv.push_back(mk(0, 1, 1, 4'h7, 16'hFFFF, 0, 16'h1234, 0, 0, 0, 16'hABCC));
    tv.push_back(mk(0, 1, 0, 4'h7, 16'h0000, 0, 16'hFFFF, 1, 0, 0, 16'hABCC));
    tv.push_back(mk(0, 1, 1, 4'h3, 16'h5555, 0, 16'hFFFF, 0, 1, 0, 16'hABCC));
    tv.push_back(mk(0, 1, 0, 4'h3, 16'h0000, 0, 16'h1007, 1, 0, 0, 16'hABCC));
    tv.push_back(mk(0, 1, 0, 4'hC, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'hABCC));
    tv.push_back(mk(0, 0, 0, 4'h7, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'hABCC));
    tv.push_back(mk(0, 1, 1, 4'h9, 16'h0F0F, 1, 16'h0000, 0, 1, 1, 16'hABCC));
    tv.push_back(mk(0, 1, 0, 4'h9, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'hABCC));
    tv.push_back(mk(0, 1, 1, 4'hA, 16'h1111, 0, 16'h0000, 0, 1, 1, 16'hABCC));
    tv.push_back(mk(0, 1, 0, 4'h8, 16'h0000, 1, 16'hABCD, 1, 0, 1, 16'hABCC));
    tv.push_back(mk(1, 1, 0, 4'h0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000));
    for (int i = 7; i < 12; i++)
      tv.push_back(mk(0, 1, 0, 4'(i), 16'h0, 0, 16'h0000, 1, 0, 0, 16'h0000));
    tv.push_back(mk(0, 1, 0, 4'h0, 16'h0000, 0, 16'hF200, 1, 0, 0, 16'h0000));
    tv.push_back(mk(0, 1, 0, 4'h6, 16'h0000, 0, 16'h4000, 1, 0, 0, 16'h0000));
    tv.push_back(mk(0, 1, 1, 4'hD, 16'h0001, 0, 16'h4000, 0, 1, 0, 16'h0000));
    tv.push_back(mk(0, 1, 1, 4'hB, 16'h0007, 0, 16'h4000, 0, 0, 0, 16'h0007));
    tv.push_back(mk(0, 1, 0, 4'hB, 16'h0000, 0, 16'h0007, 1, 0, 0, 16'h0007));
    tv.push_back(mk(0, 1, 0, 4'hF, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0007));
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].c, tv[i].w, tv[i].a, tv[i].d, tv[i].l);
      check_all(i, tv[i]);
    end
    // write during rst is discarded and leaves no strobe once rst drops
    step(0, 1, 1, 4'h9, 16'h00F0, 0);
    check("csum_pre", 100, csum, 16'h00F7);
    step(1, 1, 1, 4'h9, 16'h0A0A, 0);
    check("csum_rst", 101, csum, 16'h0000);
    step(0, 0, 0, 4'h0, 16'h0000, 0);
    check("rv_after_rst", 102, 16'(rvalid), 16'h0);
    check("err_after_rst", 103, 16'(err), 16'h0);
    step(0, 1, 0, 4'h9, 16'h0000, 0);
    check("rd9_after_rst", 104, dout, 16'h0000);
    // write then immediate read-back, then a second lock pulse while locked
    step(0, 1, 1, 4'hA, 16'h8001, 0);
    step(0, 1, 0, 4'hA, 16'h0000, 0);
    check("rd_after_wr", 105, dout, 16'h8001);
    check("csum_wrap", 106, csum, 16'h8001);
    step(0, 0, 0, 4'h0, 16'h0000, 1);
    step(0, 0, 0, 4'h0, 16'h0000, 1);
    check("lock_sticky", 107, 16'(locked), 16'h1);
    check("idle_err", 108, 16'(err), 16'h0);
    step(0, 1, 1, 4'hA, 16'h0000, 0);
    check("locked_wr_err", 109, 16'(err), 16'h1);
    check("locked_csum", 110, csum, 16'h8001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
